// File: rtl/pic_pkg.sv
// Shared types, sizes and helpers for the PIC-8259 interrupt acknowledge path.
package pic_pkg;

  localparam int NUM_IR    = 8;
  localparam int VEC_LVL_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PEND = 3'd1,
    ST_ACK1 = 3'd2,
    ST_GAP  = 3'd3,
    ST_ACK2 = 3'd4
  } ack_state_e;

  // Encodes a one-hot vector as its bit index. An all-zero input yields 0.
  function automatic logic [VEC_LVL_W-1:0] onehot_to_idx(input logic [NUM_IR-1:0] onehot);
    logic [VEC_LVL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_IR; i++) begin
      if (onehot[i]) idx = idx | VEC_LVL_W'(i);
    end
    return idx;
  endfunction

  // Returns the index of the lowest set bit. An all-zero input yields 0.
  function automatic logic [VEC_LVL_W-1:0] lowest_set(input logic [NUM_IR-1:0] bits);
    logic [VEC_LVL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (bits[i]) idx = VEC_LVL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/interrupt_ack_ctrl_if.sv
// Request/acknowledge/vector bundle between the PIC core and the acknowledge controller.
interface interrupt_ack_ctrl_if;
  import pic_pkg::*;

  logic [NUM_IR-1:0]    resolved;
  logic                 inta_n;
  logic [4:0]           vector_base;
  logic                 eoi;
  logic                 eoi_specific;
  logic [VEC_LVL_W-1:0] eoi_level;

  logic                 int_out;
  logic [NUM_IR-1:0]    irr_clr;
  logic [NUM_IR-1:0]    isr;
  logic [7:0]           vector;
  logic                 vector_oe;

  modport master (
    output resolved, inta_n, vector_base, eoi, eoi_specific, eoi_level,
    input  int_out, irr_clr, isr, vector, vector_oe
  );

  modport slave (
    input  resolved, inta_n, vector_base, eoi, eoi_specific, eoi_level,
    output int_out, irr_clr, isr, vector, vector_oe
  );

endinterface

// File: rtl/isr_reg.sv
// In-Service Register: one bit per IR level, set on acknowledge, cleared by EOI.
module isr_reg import pic_pkg::*; (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_IR-1:0]    set_vec,
  input  logic                 ns_clr,
  input  logic                 sp_clr,
  input  logic [VEC_LVL_W-1:0] sp_level,
  input  logic                 aeoi_clr,
  input  logic [VEC_LVL_W-1:0] aeoi_level,
  output logic [NUM_IR-1:0]    isr
);

  logic [NUM_IR-1:0] isr_q;
  logic [NUM_IR-1:0] isr_d;
  logic [NUM_IR-1:0] clr_mask;

  // Gather all clear sources, then OR the set last so an in-flight acknowledge survives a clash.
  always_comb begin
    clr_mask = '0;
    if (ns_clr && (isr_q != '0)) clr_mask[lowest_set(isr_q)] = 1'b1;
    if (sp_clr)                  clr_mask[sp_level]          = 1'b1;
    if (aeoi_clr)                clr_mask[aeoi_level]        = 1'b1;
    isr_d = (isr_q & ~clr_mask) | set_vec;
  end

  // ISR storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) isr_q <= '0;
    else          isr_q <= isr_d;
  end

  assign isr = isr_q;

endmodule

// File: rtl/interrupt_ack_ctrl.sv
// Acknowledge controller: gates the priority winner against the ISR, runs the
// two-pulse INTA handshake, drives the vector byte and services EOI commands.
module interrupt_ack_ctrl import pic_pkg::*; #(
  parameter bit AEOI = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  interrupt_ack_ctrl_if.slave bus
);

  ack_state_e           state_q, state_d;
  logic                 inta_d_q;
  logic [VEC_LVL_W-1:0] level_q, level_d;
  logic                 spurious_q, spurious_d;
  logic                 int_out_q, int_out_d;
  logic [NUM_IR-1:0]    irr_clr_q, irr_clr_d;
  logic [7:0]           vector_q, vector_d;
  logic                 vector_oe_q, vector_oe_d;

  logic [NUM_IR-1:0]    isr;
  logic [NUM_IR-1:0]    set_vec;
  logic                 aeoi_clr;
  logic [VEC_LVL_W-1:0] win_idx;
  logic [NUM_IR-1:0]    le_mask;
  logic                 eligible;
  logic                 fall;
  logic                 rise;

  // Fully nested mode: the winner is blocked by any in-service level at or above its priority.
  always_comb begin
    win_idx = onehot_to_idx(bus.resolved);
    le_mask = '0;
    for (int i = 0; i < NUM_IR; i++) begin
      le_mask[i] = (VEC_LVL_W'(i) <= win_idx);
    end
    eligible = (bus.resolved != '0) && ((isr & le_mask) == '0);
    fall     = inta_d_q & ~bus.inta_n;
    rise     = ~inta_d_q & bus.inta_n;
  end

  // INTA handshake sequencing; a spurious acknowledge reports level 7 and marks no ISR bit.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    spurious_d = spurious_q;
    set_vec    = '0;
    aeoi_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (eligible) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (fall) begin
          state_d = ST_ACK1;
          if (bus.resolved == '0) begin
            level_d    = VEC_LVL_W'(NUM_IR - 1);
            spurious_d = 1'b1;
          end else begin
            level_d          = win_idx;
            spurious_d       = 1'b0;
            set_vec[win_idx] = 1'b1;
          end
        end else if (!eligible) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK1: begin
        if (rise) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (fall) state_d = ST_ACK2;
      end
      ST_ACK2: begin
        if (rise) begin
          state_d = ST_IDLE;
          // A spurious cycle never set a bit, so it must not clear a genuine IR7 in service.
          aeoi_clr = AEOI && !spurious_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output registers follow the next state so every output is a flop.
  always_comb begin
    int_out_d   = (state_d == ST_PEND);
    irr_clr_d   = set_vec;
    vector_oe_d = (state_d == ST_ACK2);
    vector_d    = (state_d == ST_ACK2) ? {bus.vector_base, level_d} : vector_q;
  end

  // State, edge-detect history and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      inta_d_q    <= 1'b1;
      level_q     <= '0;
      spurious_q  <= 1'b0;
      int_out_q   <= 1'b0;
      irr_clr_q   <= '0;
      vector_q    <= '0;
      vector_oe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inta_d_q    <= bus.inta_n;
      level_q     <= level_d;
      spurious_q  <= spurious_d;
      int_out_q   <= int_out_d;
      irr_clr_q   <= irr_clr_d;
      vector_q    <= vector_d;
      vector_oe_q <= vector_oe_d;
    end
  end

  isr_reg u_isr_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_vec    (set_vec),
    .ns_clr     (bus.eoi && !bus.eoi_specific),
    .sp_clr     (bus.eoi && bus.eoi_specific),
    .sp_level   (bus.eoi_level),
    .aeoi_clr   (aeoi_clr),
    .aeoi_level (level_q),
    .isr        (isr)
  );

  assign bus.int_out   = int_out_q;
  assign bus.irr_clr   = irr_clr_q;
  assign bus.isr       = isr;
  assign bus.vector    = vector_q;
  assign bus.vector_oe = vector_oe_q;

endmodule
